// File: rtl/timer_sched.sv
// timer_sched: round-robin scheduler that shares one interval counter among
// NUM_REQ requesters. Each requester holds req high with its terminal count on
// req_len. The block grants one requester at a time, runs the counter from 0 up
// to the latched length, and pulses done to the owner. A requester can abort a
// run by dropping req.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req          per-requester request level
//   req_len      per-requester terminal count, slice i = [i*CNT_W +: CNT_W]
//   gnt          one-hot grant, high for the whole RUN of the owner
//   done         one-cycle completion pulse to the owner
//   busy         high while a run or its done cycle is in progress
//   cnt          live shared counter value
//   done_total   (TIMER_SCHED_STATS_EN only) saturating count of completed runs
//
// Optional feature macro: TIMER_SCHED_STATS_EN adds the done_total output.
module timer_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [CNT_W-1:0]         cnt
`ifdef TIMER_SCHED_STATS_EN
    ,
    output logic [15:0]              done_total
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic [IDX_W-1:0] owner_next;

    // First pending request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(idx);
            end
        end
    end

    // Round-robin pointer moves past the owner once its run ends either way.
    assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (win_vld) begin
                    owner_d = win_idx;
                    len_d   = req_len[int'(win_idx)*CNT_W +: CNT_W];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Abort wins over completion; no done pulse is produced.
                if (!req[owner_q]) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    rr_ptr_d = owner_next;
                end else if (cnt_q == len_q) begin
                    state_d = S_DONE;   // cnt holds at len_q through DONE
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                rr_ptr_d = owner_next;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decode straight from state so async reset clears them at once.
    assign gnt  = (state_q == S_RUN)  ? (NUM_REQ'(1) << owner_q) : '0;
    assign done = (state_q == S_DONE) ? (NUM_REQ'(1) << owner_q) : '0;
    assign busy = (state_q != S_IDLE);
    assign cnt  = cnt_q;

`ifdef TIMER_SCHED_STATS_EN
    logic [15:0] done_total_q, done_total_d;

    always_comb begin
        done_total_d = done_total_q;
        if (state_q == S_DONE && done_total_q != 16'hFFFF)
            done_total_d = done_total_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_total_q <= '0;
        else        done_total_q <= done_total_d;
    end

    assign done_total = done_total_q;
`endif

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Round-robin scheduler that shares one hardware interval counter among NUM_REQ requesters.
- Each requester asks for a timeout of programmable length. The block arbitrates, loads and runs the shared counter for the winner, and returns a one-cycle done pulse to it.
- Sits between the shared counter datapath and the blocks that need timed delays, so no requester drives the counter directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 8, counter and length width in bits.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level. A requester holds it high until its done pulse, or drops it to abort.
- req_len  in  NUM_REQ*CNT_W  per-requester terminal count; slice i is bits [i*CNT_W +: CNT_W].
- gnt  out  NUM_REQ  one-hot grant; high for the whole RUN of the owner.
- done  out  NUM_REQ  one-cycle pulse to the owner on completion.
- busy  out  1  high in RUN and DONE.
- cnt  out  CNT_W  live value of the shared counter.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, done=0, busy=0, cnt=0, rr_ptr=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If req!=0, pick winner w = first set req bit at or after rr_ptr, searching upward with wrap modulo NUM_REQ.
  - Next cycle: gnt[w]=1, latch len_q=req_len slice w, cnt=0, state=RUN.
  - If req==0, stay in IDLE with cnt held at 0.
- RUN:
  - If req[w]==0 (abort): next cycle gnt=0, cnt=0, state=IDLE, no done pulse. rr_ptr=(w+1) mod NUM_REQ.
  - Else if cnt==len_q: next cycle state=DONE.
  - Otherwise cnt increments by 1.
- DONE:
  - Lasts exactly one cycle: done[w]=1, gnt=0, cnt held at len_q.
  - Next cycle: state=IDLE, cnt=0, rr_ptr=(w+1) mod NUM_REQ.
- Latency for length L, with req first seen in IDLE at cycle 0:
  - gnt at cycle 1, with cnt=0.
  - cnt=L at cycle 1+L.
  - done at cycle 2+L.
  - Total RUN length is L+1 cycles.
- Boundary cases:
  - L=0: RUN lasts one cycle with cnt=0, done at cycle 2.
  - L=2^CNT_W-1: cnt reaches all-ones without wrapping; no overflow is possible.
- len_q is sampled only at grant; later changes to req_len are ignored for the current run.
- A new request arriving during RUN or DONE waits. Arbitration happens only in IDLE, so there is a minimum of one idle cycle between grants.
- A requester that keeps req high through its done pulse is treated as a new request in the following IDLE, subject to round-robin.
- Invariants:
  - gnt is zero or one-hot.
  - done is zero or one-hot.
  - done[i] implies gnt[i] was high in the previous cycle.
  - busy = (state!=IDLE).
- Reset asserted mid-run clears all outputs immediately (async) with no done pulse.

Optional Feature:
- Macro: TIMER_SCHED_STATS_EN.
- Defined:
  - Adds output done_total (16 bits): the number of completed runs (done pulses).
  - Saturates at 16'hFFFF; aborts are not counted; reset value 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Single request: req=4'b0010 with slice1=5 at cycle 0 -> gnt=4'b0010 at cycles 1..6, cnt 0..5, done=4'b0010 at cycle 7, busy low at cycle 8.
- Zero length: req[0]=1 with len=0 -> gnt[0] at cycle 1 with cnt=0, done[0] at cycle 2.
- Round-robin fairness: req=4'b1111 held high throughout, all lengths 1 -> grant order 0,1,2,3,0; each done is one-hot and precedes the next gnt by one IDLE cycle.
- Abort: req[2] dropped at cnt=3 (len=10) -> gnt=0 and cnt=0 next cycle, no done pulse, next grant goes to requester 3 if it is pending.
- Async reset mid-run: rst_n low at cnt=4 -> gnt, done, busy and cnt all 0 immediately without waiting for clk; after release the first grant is to the lowest pending index.
- Max length with stats: len=255, CNT_W=8, TIMER_SCHED_STATS_EN defined -> cnt reaches 255 without wrap, done at cycle 257, done_total increments by exactly 1.
